// File: rtl/psi_pkg.sv
// Shared constants and types for the PSI set encoder front end.
package psi_pkg;

  localparam int unsigned N_PARTIES = 5;
  localparam int unsigned B         = 10;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned PID_W     = 3;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  typedef logic [B-1:0] memb_vec_t;

endpackage

// File: rtl/psi_party_vec.sv
// One party's membership vector and set-closed flag.
module psi_party_vec
  import psi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             done_set,
  output memb_vec_t        vec,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vec  <= '0;
      done <= 1'b0;
    end else begin
      // Caller only asserts set_en for in-range indices.
      if (set_en)   vec  <= vec | (memb_vec_t'(1) << set_idx);
      if (done_set) done <= 1'b1;
    end
  end

endmodule

// File: rtl/psi_set_encoder.sv
// Collects per-party element beats into membership vectors and presents a full round.
module psi_set_encoder
  import psi_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PID_W-1:0]       in_party,
  input  logic [IDX_W-1:0]       in_idx,
  input  logic                   in_null,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_PARTIES*B-1:0] p_input,
  output logic                   err
);

  localparam logic [PID_W-1:0] PARTY_LIM = PID_W'(N_PARTIES);
  localparam logic [IDX_W-1:0] IDX_LIM   = IDX_W'(B);

  state_t                 state;
  memb_vec_t              vec [N_PARTIES];
  logic [N_PARTIES-1:0]   done;
  logic [N_PARTIES-1:0]   hit;
  logic [N_PARTIES-1:0]   set_en;
  logic [N_PARTIES-1:0]   done_set;
  logic                   accept;
  logic                   party_ok;
  logic                   idx_ok;
  logic                   party_done;
  logic                   take;
  logic                   drop;
  logic                   go_present;
  logic                   handoff;

  assign in_ready  = (state == COLLECT) && !rst;
  assign out_valid = (state == PRESENT);
  assign accept    = in_valid && in_ready;
  assign handoff   = (state == PRESENT) && out_ready;

  assign party_ok  = in_party < PARTY_LIM;
  assign idx_ok    = in_idx < IDX_LIM;

  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < N_PARTIES; k++) begin
      hit[k] = (in_party == PID_W'(k));
    end
  end

  assign party_done = |(hit & done);
  assign take       = accept && party_ok && !party_done;
  assign set_en     = (take && !in_null && idx_ok) ? hit : '0;
  assign done_set   = (take && in_last) ? hit : '0;
  assign drop       = accept && (!party_ok || party_done || (!in_null && !idx_ok));
  assign go_present = accept && (&(done | done_set));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      err   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (drop)       err   <= 1'b1;
          if (go_present) state <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            state <= COLLECT;
            err   <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  for (genvar k = 0; k < N_PARTIES; k++) begin : g_party
    psi_party_vec u_vec (
      .clk      (clk),
      .rst      (rst),
      .clr      (handoff),
      .set_en   (set_en[k]),
      .set_idx  (in_idx),
      .done_set (done_set[k]),
      .vec      (vec[k]),
      .done     (done[k])
    );
    assign p_input[k*B +: B] = vec[k];
  end

endmodule

// File: tb/tb_psi_set_encoder.sv
// Self-checking bench for psi_set_encoder against a set-level reference model.
module tb_psi_set_encoder;
  import psi_pkg::*;

  localparam int W = N_PARTIES * B;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PID_W-1:0] in_party = '0;
  logic [IDX_W-1:0] in_idx = '0;
  logic             in_null = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     p_input;
  logic             err;

  int checks = 0;
  int errors = 0;

  // Reference model: which (party, element) pairs are members, who closed, any drop.
  bit m_member[N_PARTIES][B];
  bit m_done[N_PARTIES];
  bit m_err;
  bit m_present;

  psi_set_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_party  (in_party),
    .in_idx    (in_idx),
    .in_null   (in_null),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_input   (p_input),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_p();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N_PARTIES; k++)
      for (int i = 0; i < B; i++)
        if (m_member[k][i]) r = r | ({{(W-1){1'b0}}, 1'b1} << (k * B + i));
    return r;
  endfunction

  function automatic int closed_count();
    int n;
    n = 0;
    for (int k = 0; k < N_PARTIES; k++) if (m_done[k]) n++;
    return n;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < N_PARTIES; k++) begin
      m_done[k] = 0;
      for (int i = 0; i < B; i++) m_member[k][i] = 0;
    end
    m_err     = 0;
    m_present = 0;
  endfunction

  function automatic void model_beat(int party, int idx, bit nul, bit last);
    if (m_present) return;
    if (party >= N_PARTIES || m_done[party]) begin
      m_err = 1;
      return;
    end
    if (!nul) begin
      if (idx < B) m_member[party][idx] = 1;
      else m_err = 1;
    end
    if (last) m_done[party] = 1;
    if (closed_count() == N_PARTIES) m_present = 1;
  endfunction

  task automatic drive_beat(input int party, input int idx, input bit nul, input bit last);
    logic [31:0] pv, iv;
    pv = party;
    iv = idx;
    @(negedge clk);
    in_valid = 1'b1;
    in_party = pv[PID_W-1:0];
    in_idx   = iv[IDX_W-1:0];
    in_null  = nul;
    in_last  = last;
    @(posedge clk);
    model_beat(party, idx, nul, last);
    #1;
    in_valid = 1'b0;
    in_null  = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drive_handoff();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    if (m_present) model_clear();
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (p_input !== '0) begin errors++; $display("FAIL reset_p_input: got %h want 0", p_input); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_round();
    logic [W-1:0] want;
    want = '0;
    for (int k = 0; k < N_PARTIES; k++) begin
      want[k*B + 3] = 1'b1;
      want[k*B + 7] = 1'b1;
    end
    for (int k = 0; k < N_PARTIES; k++) begin
      drive_beat(k, 3, 0, 0);
      if (k == N_PARTIES - 1) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
      end
      drive_beat(k, 7, 0, 1);
    end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got %b want 1", out_valid); end
    @(negedge clk);
    checks++;
    if (p_input !== want) begin errors++; $display("FAIL single_const: got %h want %h", p_input, want); end
    checks++;
    if (p_input !== exp_p()) begin errors++; $display("FAIL single_model: got %h want %h", p_input, exp_p()); end
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL single_err_ready: got err=%b rdy=%b want 0 0", err, in_ready); end
    drive_handoff();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p_input !== '0) begin
      errors++; $display("FAIL single_handoff: got rdy=%b vld=%b p=%h want 1 0 0", in_ready, out_valid, p_input);
    end
  endtask

  task automatic test_empty_set();
    logic [W-1:0] want;
    want = 50'h100_4000_0401;
    for (int k = 0; k < N_PARTIES; k++) begin
      if (k == 2) drive_beat(k, 9, 1, 1);
      else drive_beat(k, 0, 0, 1);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL empty_valid: got %b want 1", out_valid); end
    checks++;
    if (p_input !== want || p_input !== exp_p()) begin errors++; $display("FAIL empty_p_input: got %h want %h", p_input, want); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL empty_err: got %b want 0", err); end
    drive_handoff();
  endtask

  task automatic test_errors();
    drive_beat(6, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || p_input !== '0) begin errors++; $display("FAIL err_bad_party: got err=%b p=%h want 1 0", err, p_input); end
    drive_beat(1, 12, 0, 0);
    drive_beat(0, 2, 0, 1);
    drive_beat(0, 4, 0, 0);
    @(negedge clk);
    checks++;
    if (p_input !== exp_p() || out_valid !== 1'b0) begin errors++; $display("FAIL err_drops: got p=%h vld=%b want %h 0", p_input, out_valid, exp_p()); end
    drive_beat(1, 15, 0, 1);
    for (int k = 2; k < N_PARTIES; k++) drive_beat(k, k, 0, 1);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || err !== 1'b1 || p_input !== exp_p()) begin
        errors++; $display("FAIL err_present: got vld=%b err=%b p=%h want 1 1 %h", out_valid, err, p_input, exp_p());
      end
    end
    drive_handoff();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    for (int k = 0; k < N_PARTIES; k++) drive_beat(k, $urandom_range(0, B - 1), 0, 1);
    @(negedge clk);
    held = p_input;
    checks++;
    if (held !== exp_p()) begin errors++; $display("FAIL bp_p_input: got %h want %h", held, exp_p()); end
    for (int c = 0; c < 10; c++) begin
      if (c == 4) drive_beat(0, 1, 0, 1);
      else @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || p_input !== held) begin
        errors++; $display("FAIL bp_stall: cyc %0d got vld=%b rdy=%b p=%h want 1 0 %h", c, out_valid, in_ready, p_input, held);
      end
    end
    drive_handoff();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || p_input !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got rdy=%b p=%h vld=%b want 1 0 0", in_ready, p_input, out_valid);
    end
  endtask

  task automatic test_interleave();
    int order[7] = '{4, 0, 4, 2, 1, 3, 0};
    int idxs[7]  = '{5, 1, 5, 8, 2, 9, 6};
    for (int j = 0; j < 7; j++) drive_beat(order[j], idxs[j], 0, 0);
    @(negedge clk);
    checks++;
    if (p_input[45] !== 1'b1 || p_input !== exp_p() || err !== 1'b0) begin
      errors++; $display("FAIL interleave_mid: got p=%h err=%b want %h 0", p_input, err, exp_p());
    end
    drive_beat(3, 0, 1, 1);
    drive_beat(0, 0, 1, 1);
    drive_beat(4, 5, 0, 1);
    drive_beat(2, 0, 1, 1);
    drive_beat(1, 0, 1, 1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || p_input !== exp_p() || err !== 1'b0) begin
      errors++; $display("FAIL interleave_end: got vld=%b p=%h err=%b want 1 %h 0", out_valid, p_input, err, exp_p());
    end
    drive_handoff();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) drive_beat(k, k + 4, 0, 1);
    drive_beat(7, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
    @(posedge clk);
    model_clear();
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (p_input !== '0 || out_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_state: got p=%h vld=%b err=%b rdy=%b want 0 0 0 1", p_input, out_valid, err, in_ready);
    end
    for (int k = N_PARTIES - 1; k >= 0; k--) drive_beat(k, 9 - k, 0, 1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || p_input !== exp_p() || err !== 1'b0) begin
      errors++; $display("FAIL rstmid_fresh: got vld=%b p=%h err=%b want 1 %h 0", out_valid, p_input, err, exp_p());
    end
    drive_handoff();
  endtask

  task automatic test_random_rounds();
    for (int r = 0; r < 20; r++) begin
      for (int b = 0; b < 40 && !m_present; b++) begin
        drive_beat($urandom_range(0, 7), $urandom_range(0, 15), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 9) == 0));
        checks++;
        if (out_valid !== m_present || p_input !== exp_p() || err !== m_err) begin
          errors++;
          $display("FAIL rand_beat r%0d b%0d: got vld=%b p=%h err=%b want %b %h %b",
                   r, b, out_valid, p_input, err, m_present, exp_p(), m_err);
        end
      end
      for (int k = 0; k < N_PARTIES; k++)
        if (!m_present && !m_done[k]) drive_beat(k, $urandom_range(0, B - 1), 0, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || p_input !== exp_p() || err !== m_err) begin
        errors++;
        $display("FAIL rand_round r%0d: got vld=%b p=%h err=%b want 1 %h %b", r, out_valid, p_input, err, exp_p(), m_err);
      end
      drive_handoff();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_round();
    test_empty_set();
    test_errors();
    test_backpressure();
    test_interleave();
    test_reset_mid();
    test_random_rounds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
